// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch front end. Owns the PC, issues one word
//                read per cycle to inst_rom under a credit limit, buffers the
//                returned words with their PC in a prefetch queue, hands them
//                to decode over valid/ready, and applies branch/jump/register
//                /restart redirects with flush. A misaligned register target
//                halts fetch in a sticky fault state until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0040_0000)
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redir_valid,
  input  logic [1:0]      redir_mode,
  input  logic [XLEN-1:0] redir_base,
  input  logic [25:0]     redir_imm,
  input  logic [XLEN-1:0] redir_reg,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  localparam int              PW        = $clog2(DEPTH);
  localparam int              CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
  localparam logic [1:0]      MODE_BR   = 2'd0;
  localparam logic [1:0]      MODE_JMP  = 2'd1;
  localparam logic [1:0]      MODE_REG  = 2'd2;
  localparam logic [XLEN-1:0] JUMP_MASK = {{(XLEN-28){1'b1}}, 28'h0};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [XLEN-1:0] fetch_pc;
  logic [31:0]     q_inst [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   credit;
  logic            do_redirect;
  logic            do_fault;
  logic            flush;
  logic            push;
  logic            pop;

  // Redirect target for the requested mode; all sums wrap at XLEN bits.
  always_comb begin
    pc_plus4 = redir_base + XLEN'(4);
    br_off   = {{(XLEN-18){redir_imm[15]}}, redir_imm[15:0], 2'b00};
    target   = RESET_PC;
    case (redir_mode)
      MODE_BR:  target = pc_plus4 + br_off;
      MODE_JMP: target = (pc_plus4 & JUMP_MASK) | XLEN'({redir_imm, 2'b00});
      MODE_REG: target = redir_reg;
      default:  target = RESET_PC;
    endcase
  end

  // Words already buffered plus the one on its way back from the ROM.
  assign credit = count + CW'(inflight);

  // Run/fault state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state plus issue/redirect decisions; reset overrides everything.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    do_redirect = 1'b0;
    do_fault    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redir_valid) begin
          if (redir_mode == MODE_REG && target[1:0] != 2'b00) begin
            state_d  = ST_FAULT;
            do_fault = 1'b1;
          end else begin
            do_redirect = 1'b1;
          end
        end else if (credit < DEPTH_C) begin
          imem_req = 1'b1;
        end
      end
      default: state_d = state_q;
    endcase
    if (reset) begin
      state_d     = ST_RUN;
      imem_req    = 1'b0;
      do_redirect = 1'b0;
      do_fault    = 1'b0;
    end
  end

  assign flush      = do_redirect | do_fault;
  assign inst_valid = !reset && (state_q == ST_RUN) && (count != '0);
  assign push       = inflight & ~flush;
  assign pop        = inst_valid & inst_ready & ~flush;
  assign imem_addr  = fetch_pc;
  assign inst       = q_inst[head];
  assign inst_pc    = q_pc[head];
  assign fault      = (state_q == ST_FAULT);

  // PC, queue pointers/occupancy, in-flight tracking and fault capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fault_pc    <= '0;
    end else begin
      inflight    <= imem_req;
      inflight_pc <= fetch_pc;
      if (do_redirect)   fetch_pc <= target;
      else if (imem_req) fetch_pc <= fetch_pc + XLEN'(4);
      if (do_fault) fault_pc <= target;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage: the returning word lands at the tail with its PC.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      q_inst[tail] <= imem_rdata;
      q_pc[tail]   <= inflight_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A queue-based model of
//                the fetch front end predicts every output each cycle;
//                directed scenarios pin key values with literals, then a
//                randomized phase exercises ready, redirects and resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redir_valid;
  logic [1:0]  redir_mode;
  logic [31:0] redir_base;
  logic [25:0] redir_imm;
  logic [31:0] redir_reg;
  logic        fault;
  logic [31:0] fault_pc;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .redir_valid(redir_valid),
    .redir_mode (redir_mode),
    .redir_base (redir_base),
    .redir_imm  (redir_imm),
    .redir_reg  (redir_reg),
    .fault      (fault),
    .fault_pc   (fault_pc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] rom(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Redirect target straight from the architectural formulas.
  function automatic logic [31:0] model_target(logic [1:0] m, logic [31:0] b,
                                               logic [25:0] im, logic [31:0] rg);
    int          si;
    logic [31:0] pc4;
    pc4 = b + 32'd4;
    case (m)
      2'd0: begin
        si = $signed(im[15:0]);
        return pc4 + 32'(si * 4);
      end
      2'd1:    return (pc4 & 32'hF000_0000) | (32'(im) << 2);
      2'd2:    return rg;
      default: return RPC;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  // Instruction memory: answers a request one cycle later; junk otherwise.
  initial begin
    logic        pv;
    logic [31:0] pa;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      pv = imem_req;
      pa = imem_addr;
      @(posedge clock);
      #1;
      imem_rdata = pv ? rom(pa) : 32'($urandom);
    end
  end

  // Reference model and per-cycle comparison.
  initial begin
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_infl_pc;
    logic [31:0] m_fpc;
    logic [31:0] tgt;
    bit          m_infl;
    bit          m_fault;
    bit          started;
    bit          exp_req;
    bit          exp_valid;
    m_pc = RPC; m_infl_pc = '0; m_fpc = '0;
    m_infl = 0; m_fault = 0; started = 0;
    forever begin
      @(negedge clock);
      exp_req   = !reset && !m_fault && !redir_valid &&
                  ((m_q.size() + int'(m_infl)) < DEPTH);
      exp_valid = !reset && !m_fault && (m_q.size() != 0);
      if (started) begin
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("inst_valid", inst_valid, exp_valid);
        if (exp_valid) begin
          chk("inst_pc", inst_pc, m_q[0]);
          chk("inst", inst, rom(m_q[0]));
        end
        chk("fault", fault, m_fault);
        if (m_fault) chk("fault_pc", fault_pc, m_fpc);
      end
      if (reset) begin
        m_pc = RPC; m_q.delete(); m_infl = 0; m_fault = 0; m_fpc = '0;
        started = 1;
      end else if (m_fault) begin
        m_infl = 0;
      end else if (redir_valid) begin
        tgt = model_target(redir_mode, redir_base, redir_imm, redir_reg);
        m_q.delete();
        m_infl = 0;
        if (redir_mode == 2'd2 && tgt[1:0] != 2'b00) begin
          m_fault = 1;
          m_fpc   = tgt;
        end else begin
          m_pc = tgt;
        end
      end else begin
        if (exp_valid && inst_ready) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_infl_pc);
        m_infl    = exp_req;
        m_infl_pc = m_pc;
        if (exp_req) m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) next();
    reset = 1'b0;
  endtask

  // Pulse a redirect, then expect two empty cycles and the target on the third.
  task automatic redirect_expect(string name, logic [1:0] m, logic [31:0] b,
                                 logic [25:0] im, logic [31:0] exp_pc);
    redir_valid = 1'b1; redir_mode = m; redir_base = b; redir_imm = im;
    next();
    redir_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      if (k < 3) chk({name, "_gap"}, inst_valid, 1'b0);
      else begin
        chk({name, "_valid"}, inst_valid, 1'b1);
        chk({name, "_pc"}, inst_pc, exp_pc);
      end
      next();
    end
  endtask

  initial begin
    int nreq;
    reset = 1'b1; inst_ready = 1'b1; redir_valid = 1'b0; redir_mode = 2'd0;
    redir_base = '0; redir_imm = '0; redir_reg = '0;

    chk("model_branch", model_target(2'd0, 32'h0040_0010, 26'h000FFFC, 32'h0), 32'h0040_0004);
    chk("model_jump", model_target(2'd1, 32'h0040_001C, 26'h0100008, 32'h0), 32'h0040_0020);
    chk("model_restart", model_target(2'd3, 32'h1234_5678, 26'h0, 32'h0), RPC);

    // T1: sequential stream, first word in cycle 2, one per cycle
    repeat (3) next();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (k == 0) begin
        chk("t1_first_req", imem_req, 1'b1);
        chk("t1_first_addr", imem_addr, RPC);
      end
      if (k < 2) chk("t1_latency", inst_valid, 1'b0);
      else begin
        chk("t1_valid", inst_valid, 1'b1);
        chk("t1_pc", inst_pc, RPC + 32'(4 * (k - 2)));
      end
      next();
    end

    // T2: stalled decode fills exactly DEPTH entries, then drains in order
    inst_ready = 1'b0;
    do_reset(2);
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (imem_req) nreq++;
      next();
    end
    chk("t2_req_count", nreq, 4);
    inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("t2_valid", inst_valid, 1'b1);
      chk("t2_pc", inst_pc, RPC + 32'(4 * k));
      next();
    end

    // T3/T4: backward branch, then jump with a response in flight
    redirect_expect("t3_branch", 2'd0, 32'h0040_0010, 26'h000FFFC, 32'h0040_0004);
    redirect_expect("t4_jump", 2'd1, 32'h0040_001C, 26'h0100008, 32'h0040_0020);

    // T5: misaligned register target faults; later redirect ignored
    redir_valid = 1'b1; redir_mode = 2'd2; redir_reg = 32'h0040_0002;
    next();
    for (int k = 0; k < 5; k++) begin
      redir_valid = (k == 2);
      redir_mode  = 2'd3;
      @(negedge clock);
      chk("t5_fault", fault, 1'b1);
      chk("t5_fault_pc", fault_pc, 32'h0040_0002);
      chk("t5_no_req", imem_req, 1'b0);
      chk("t5_no_valid", inst_valid, 1'b0);
      next();
    end
    redir_valid = 1'b0;

    // T6: reset with a full queue, then wrap of the PC past the top
    inst_ready = 1'b0;
    do_reset(1);
    repeat (6) next();
    reset = 1'b1;
    @(negedge clock);
    chk("t6_rst_valid", inst_valid, 1'b0);
    chk("t6_rst_req", imem_req, 1'b0);
    next();
    reset = 1'b0;
    @(negedge clock);
    chk("t6_post_valid", inst_valid, 1'b0);
    chk("t6_post_req", imem_req, 1'b1);
    chk("t6_post_addr", imem_addr, RPC);
    next();
    inst_ready = 1'b1;
    redir_valid = 1'b1; redir_mode = 2'd2; redir_reg = 32'hFFFF_FFFC;
    next();
    redir_valid = 1'b0;
    @(negedge clock);
    chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    next();
    @(negedge clock);
    chk("t6_wrap_req", imem_req, 1'b1);
    chk("t6_wrap_addr", imem_addr, 32'h0000_0000);
    next();
    @(negedge clock);
    chk("t6_top_pc", inst_pc, 32'hFFFF_FFFC);
    next();
    @(negedge clock);
    chk("t6_wrap_pc", inst_pc, 32'h0000_0000);
    next();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      reset       = ($urandom_range(149) == 0);
      inst_ready  = ($urandom_range(3) != 0);
      redir_valid = ($urandom_range(11) == 0);
      redir_mode  = 2'($urandom_range(3));
      redir_base  = 32'($urandom) & 32'hFFFF_FFFC;
      redir_imm   = 26'($urandom);
      redir_reg   = 32'($urandom);
      if ($urandom_range(5) != 0) redir_reg = redir_reg & 32'hFFFF_FFFC;
      next();
    end
    reset = 1'b0; redir_valid = 1'b0;
    repeat (2) next();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
